fifo_block_unpack: RTL and testbench
====================================

Name: fifo_block_unpack

Overview:
- Width-down converter and block buffer for the AES datapath output side.
- Accepts full 256-bit blocks, such as a key or ciphertext pair from the core, and streams them out as 32-bit words over a valid/ready handshake.
- Mirrors the 32-to-256 seed packer: word 0 is bits [31:0] and is emitted first.
- Holds up to DEPTH whole blocks, so the core can deposit the next block while the current one drains.

Parameters:
- DATA_IN_WH, 256, input block width; must be an integer multiple of DATA_OUT_WH.
- DATA_OUT_WH, 32, output word width.
- DEPTH, 2, number of whole blocks buffered; must be >= 1.
- WORDS (localparam), DATA_IN_WH/DATA_OUT_WH = 8, words per block.

Ports:
- clk  input  1  clock, all logic on rising edge.
- resetn  input  1  synchronous, active-low reset.
- in_valid  input  1  producer has a block on in_data.
- in_ready  output  1  block slot free; high when block count < DEPTH.
- in_data  input  DATA_IN_WH  block to unpack; sampled only on accept.
- out_valid  output  1  word available on out_data.
- out_ready  input  1  consumer takes the word this cycle.
- out_data  output  DATA_OUT_WH  current word.
- out_last  output  1  out_data is the final word of its block.
- words_avail  output  $clog2(WORDS*DEPTH)+1  words not yet popped (5 bits at defaults).
- empty  output  1  block count == 0.
- full  output  1  block count == DEPTH.

Behaviour:
- Reset values (resetn low at a rising edge):
  - block count, write slot, read slot and word_ptr = 0.
  - Buffered data discarded; memory contents need no reset.
  - Outputs: in_ready = 1, out_valid = 0, out_last = 0, out_data = 0, words_avail = 0, empty = 1, full = 0.
- Reset mid-operation: all queued words are lost on that edge; no partial word is emitted afterwards.
- Accept:
  - in_valid & in_ready at an edge writes in_data into the write slot.
  - Write slot advances modulo DEPTH; block count increments.
  - in_ready, full and empty are decoded from registered count only, so no combinational path from out_ready to in_ready.
- Load latency: a block accepted at edge N gives out_valid = 1 and out_data = word 0 from just after edge N, i.e. the first word can pop at edge N+1.
- Output datapath:
  - out_valid = !empty.
  - out_data = read slot bits [word_ptr*DATA_OUT_WH +: DATA_OUT_WH] when out_valid, else 0.
  - out_last = out_valid & (word_ptr == WORDS-1).
- Pop (out_valid & out_ready at an edge):
  - If word_ptr < WORDS-1: word_ptr increments.
  - Else: word_ptr wraps to 0, read slot advances modulo DEPTH, block count decrements.
- Backpressure: with out_valid = 1 and out_ready = 0, out_data, out_last and word_ptr hold.
- words_avail = count*WORDS - word_ptr; combinational from registers, range 0..WORDS*DEPTH.
- Simultaneous accept and final-word pop:
  - Count unchanged; new block lands in the write slot; read slot advances.
  - At count 1, output moves straight to word 0 of the new block with no bubble.
- Full:
  - in_ready = 0 even when the final word pops in the same cycle; no pass-through.
  - in_valid is ignored and in_data is not sampled.
- Empty: out_ready is ignored; word_ptr stays 0.
- No error outputs. Overflow and underflow cannot occur through the handshake.

Test Plan:
- Reset: hold resetn = 0 for 2 cycles -> in_ready = 1, out_valid = 0, empty = 1, full = 0, words_avail = 0, out_data = 0.
- Single-block drain:
  - Stimulus: in_data = {32'h7,32'h6,...,32'h0} accepted at edge N, out_ready = 1.
  - Required: pops at edges N+1..N+8 yield words 0,1,...,7.
  - Required: out_last high only on word 7; then empty = 1, words_avail = 0.
- Backpressure:
  - Stimulus: load {32'hA7..32'hA0}; out_ready pattern 1,0,0,1,1,0,1,1,1,1.
  - Required: exactly 8 pops, in order A0..A7, with out_data stable during each stall.
- Fill to full:
  - Stimulus: accept blocks B and C with out_ready = 0, then hold in_valid with block D.
  - Required: full = 1, in_ready = 0, words_avail = 16; D is never accepted.
  - Required: after out_ready = 1, 16 words of B then C; D accepted on the edge after B's last word pops.
- Accept on last pop at count 1:
  - Stimulus: drain block E to word 7 and present block F with in_valid on the same edge as E's last pop.
  - Required: next cycle out_data = F word 0, count = 1, words_avail = 8, no empty cycle.
- Reset mid-drain:
  - Stimulus: after popping 3 words of block G, pulse resetn = 0 for 1 cycle.
  - Required: empty = 1, words_avail = 0.
  - Required: a new block H then emits H word 0 first.

Source files
------------

// File: rtl/fifo_block_unpack.sv
// rtl/fifo_block_unpack.sv - block-wide FIFO that streams each buffered block out as narrow words
module fifo_block_unpack #(
    parameter int DATA_IN_WH  = 256,
    parameter int DATA_OUT_WH = 32,
    parameter int DEPTH       = 2
) (
    input  logic                                              clk,
    input  logic                                              resetn,
    input  logic                                              in_valid,
    output logic                                              in_ready,
    input  logic [DATA_IN_WH-1:0]                             in_data,
    output logic                                              out_valid,
    input  logic                                              out_ready,
    output logic [DATA_OUT_WH-1:0]                            out_data,
    output logic                                              out_last,
    output logic [$clog2((DATA_IN_WH/DATA_OUT_WH)*DEPTH):0]   words_avail,
    output logic                                              empty,
    output logic                                              full
);

    localparam int WORDS = DATA_IN_WH / DATA_OUT_WH;
    localparam int AW    = $clog2(WORDS * DEPTH) + 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int SW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [DATA_IN_WH-1:0] r_mem [DEPTH];
    logic [CW-1:0]         r_count;
    logic [SW-1:0]         r_wr_slot;
    logic [SW-1:0]         r_rd_slot;
    logic [PW-1:0]         r_word_ptr;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_pop_last;
    logic                   w_at_last_word;
    logic [DATA_IN_WH-1:0]  w_rd_block;
    logic [DATA_OUT_WH-1:0] w_word;

    function automatic logic [SW-1:0] f_next_slot(input logic [SW-1:0] s);
        return (s == SW'(DEPTH - 1)) ? '0 : s + SW'(1);
    endfunction

    // Flags come from the registered block count only, so in_ready never depends on out_ready.
    assign empty     = (r_count == '0);
    assign full      = (r_count == CW'(DEPTH));
    assign in_ready  = !full;
    assign out_valid = !empty;

    assign w_at_last_word = (r_word_ptr == PW'(WORDS - 1));
    assign w_push         = in_valid & in_ready;
    assign w_pop          = out_valid & out_ready;
    assign w_pop_last     = w_pop & w_at_last_word;

    assign w_rd_block = r_mem[r_rd_slot];
    assign w_word     = w_rd_block[r_word_ptr*DATA_OUT_WH +: DATA_OUT_WH];

    assign out_data    = out_valid ? w_word : '0;
    assign out_last    = out_valid & w_at_last_word;
    assign words_avail = AW'(r_count) * AW'(WORDS) - AW'(r_word_ptr);

    // Block storage; contents are don't-care until a slot is written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_slot] <= in_data;
        end
    end

    // Write slot, read slot, word pointer and block count bookkeeping.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_count    <= '0;
            r_wr_slot  <= '0;
            r_rd_slot  <= '0;
            r_word_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_slot <= f_next_slot(r_wr_slot);
            end
            if (w_pop) begin
                if (w_at_last_word) begin
                    r_word_ptr <= '0;
                    r_rd_slot  <= f_next_slot(r_rd_slot);
                end else begin
                    r_word_ptr <= r_word_ptr + PW'(1);
                end
            end
            if (w_push && !w_pop_last) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop_last) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_block_unpack.sv
// tb/tb_fifo_block_unpack.sv - directed scoreboard bench for fifo_block_unpack
module tb_fifo_block_unpack;

    localparam int DIN   = 256;
    localparam int DOUT  = 32;
    localparam int DEPTH = 2;
    localparam int WORDS = DIN / DOUT;

    logic            clk;
    logic            resetn;
    logic            in_valid;
    logic            in_ready;
    logic [DIN-1:0]  in_data;
    logic            out_valid;
    logic            out_ready;
    logic [DOUT-1:0] out_data;
    logic            out_last;
    logic [4:0]      words_avail;
    logic            empty;
    logic            full;

    int n_pass;
    int n_total;

    // Scoreboard entries: {last flag, word}
    logic [DOUT:0] sb_q[$];

    fifo_block_unpack #(
        .DATA_IN_WH (DIN),
        .DATA_OUT_WH(DOUT),
        .DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .words_avail(words_avail),
        .empty      (empty),
        .full       (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DIN-1:0] make_blk(input logic [DOUT-1:0] base);
        logic [DIN-1:0] b;
        b = '0;
        for (int i = 0; i < WORDS; i++) begin
            b[i*DOUT +: DOUT] = base + DOUT'(i);
        end
        return b;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Compare all outputs to the model, clock one edge, update the model. Called just after a negedge.
    task automatic cycle(output bit accepted);
        int  qn;
        int  mcount;
        bit  pop;
        qn     = sb_q.size();
        mcount = (qn + WORDS - 1) / WORDS;
        chk("in_ready",    64'(in_ready),    64'(mcount < DEPTH));
        chk("full",        64'(full),        64'(mcount == DEPTH));
        chk("empty",       64'(empty),       64'(qn == 0));
        chk("out_valid",   64'(out_valid),   64'(qn != 0));
        chk("words_avail", 64'(words_avail), 64'(qn));
        chk("out_data",    64'(out_data),    (qn != 0) ? 64'(sb_q[0][DOUT-1:0]) : 64'd0);
        chk("out_last",    64'(out_last),    (qn != 0) ? 64'(sb_q[0][DOUT]) : 64'd0);
        accepted = resetn && in_valid && (mcount < DEPTH);
        pop      = resetn && out_ready && (qn != 0);
        @(posedge clk);
        if (!resetn) begin
            sb_q.delete();
        end else begin
            if (pop) void'(sb_q.pop_front());
            if (accepted) begin
                for (int i = 0; i < WORDS; i++) begin
                    sb_q.push_back({(i == WORDS - 1), in_data[i*DOUT +: DOUT]});
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        bit acc;
        int acc_iter;
        n_pass    = 0;
        n_total   = 0;
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset held for two edges
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",    64'(in_ready),    64'd1);
        chk("rst_out_valid",   64'(out_valid),   64'd0);
        chk("rst_empty",       64'(empty),       64'd1);
        chk("rst_full",        64'(full),        64'd0);
        chk("rst_words_avail", 64'(words_avail), 64'd0);
        chk("rst_out_data",    64'(out_data),    64'd0);
        chk("rst_out_last",    64'(out_last),    64'd0);
        resetn = 1'b1;

        // Single-block drain with consumer always ready
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = make_blk(32'h0);
        cycle(acc);
        chk("single_acc", 64'(acc), 64'd1);
        in_valid = 1'b0;
        repeat (WORDS) cycle(acc);
        chk("single_empty", 64'(empty),       64'd1);
        chk("single_avail", 64'(words_avail), 64'd0);

        // Backpressure pattern on block A
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = make_blk(32'hA0);
        cycle(acc);
        in_valid = 1'b0;
        begin
            logic [9:0] pat;
            pat = 10'b1111011001;
            for (int i = 0; i < 10; i++) begin
                out_ready = pat[i];
                cycle(acc);
            end
        end
        out_ready = 1'b1;
        while (sb_q.size() != 0 && n_total < 5000) cycle(acc);
        cycle(acc);
        chk("bp_drained", 64'(empty), 64'd1);

        // Fill to full with B and C, then hold D
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = make_blk(32'hB0);
        cycle(acc);
        in_data = make_blk(32'hC0);
        cycle(acc);
        in_data = make_blk(32'hD0);
        cycle(acc);
        chk("full_d_rejected", 64'(acc), 64'd0);
        cycle(acc);
        chk("full_flag",  64'(full),        64'd1);
        chk("full_avail", 64'(words_avail), 64'd16);
        out_ready = 1'b1;
        acc_iter  = -1;
        for (int i = 0; i < 30; i++) begin
            cycle(acc);
            if (acc) begin
                acc_iter = i;
                in_valid = 1'b0;
            end
        end
        chk("d_accept_edge", 64'(acc_iter), 64'd8);
        chk("full_drained",  64'(empty),    64'd1);

        // Accept F on the same edge that pops E's last word
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = make_blk(32'hE0);
        cycle(acc);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (WORDS - 1) cycle(acc);
        chk("e_last_word", 64'(out_last), 64'd1);
        in_valid = 1'b1;
        in_data  = make_blk(32'hF0);
        cycle(acc);
        chk("f_acc", 64'(acc), 64'd1);
        in_valid = 1'b0;
        chk("f_word0", 64'(out_data),    64'h0000_00F0);
        chk("f_avail", 64'(words_avail), 64'd8);
        chk("f_valid", 64'(out_valid),   64'd1);
        repeat (WORDS) cycle(acc);

        // Reset in the middle of draining G, then H
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = make_blk(32'h60);
        cycle(acc);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) cycle(acc);
        resetn = 1'b0;
        cycle(acc);
        resetn = 1'b1;
        chk("midrst_empty", 64'(empty),       64'd1);
        chk("midrst_avail", 64'(words_avail), 64'd0);
        cycle(acc);
        in_valid = 1'b1;
        in_data  = make_blk(32'h480);
        cycle(acc);
        in_valid = 1'b0;
        chk("h_word0", 64'(out_data), 64'h0000_0480);
        repeat (WORDS + 1) cycle(acc);
        chk("h_drained", 64'(empty), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Absolute time bound so the bench can never hang
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
